// File: rtl/msg_length_scanner.sv
// msg_length_scanner
//   Finds the bit length of a message for the SHA-256 padding stage. A start
//   latches the message, the terminator symbol and the match mode, then
//   LANES symbols are compared per clock. The reported length runs up to and
//   including the first (mode 0) or last (mode 1) terminator occurrence.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   start      scan request, accepted only while busy=0
//   mess       message, symbol i at mess[i*SYM_W +: SYM_W]
//   last_word  terminator symbol
//   mode       0 = first match, 1 = last match
//   busy       high while scanning and during the done cycle
//   done       one-cycle pulse, found/size valid
//   found      at least one match in the last completed scan
//   size       (idx+1)*SYM_W of the selected match, 0 if none
//
// state | meaning
// IDLE  | waiting for start
// SCAN  | comparing one beat of LANES symbols per cycle
// DONE  | result presented, done pulse
module msg_length_scanner #(
    parameter int SYM_W   = 4,
    parameter int NUM_SYM = 128,
    parameter int LANES   = 8,
    parameter int LEN_W   = $clog2(NUM_SYM*SYM_W)+1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [NUM_SYM*SYM_W-1:0] mess,
    input  logic [SYM_W-1:0]         last_word,
    input  logic                     mode,
    output logic                     busy,
    output logic                     done,
    output logic                     found,
    output logic [LEN_W-1:0]         size
);

    localparam int NUM_BEATS = NUM_SYM / LANES;
    localparam int BEAT_W    = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
    localparam int IDX_W     = (NUM_SYM > 1) ? $clog2(NUM_SYM) : 1;
    localparam int MSG_W     = NUM_SYM * SYM_W;

    generate
        if (LANES < 1 || (NUM_SYM % LANES) != 0) begin : g_bad_lanes
            $error("msg_length_scanner: LANES must divide NUM_SYM");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t             state, state_nxt;
    logic [MSG_W-1:0]   mess_q;
    logic [SYM_W-1:0]   term_q;
    logic               mode_q;
    logic [BEAT_W-1:0]  beat;
    logic               hit_q, hit_nxt;
    logic [IDX_W-1:0]   idx_q, idx_nxt;
    logic [LEN_W-1:0]   size_nxt;
    logic [LANES-1:0]   lane_hit;
    logic               accept;
    int                 lo_lane, hi_lane;

    // The latched message is shifted down one beat per SCAN cycle, so the
    // current beat always sits in the low LANES symbols. This avoids a wide
    // beat-indexed mux in front of the comparators.
    always_comb begin
        lane_hit = '0;
        for (int l = 0; l < LANES; l++)
            lane_hit[l] = (mess_q[l*SYM_W +: SYM_W] == term_q);
    end

    always_comb begin
        lo_lane = 0;
        hi_lane = 0;
        for (int l = LANES-1; l >= 0; l--)
            if (lane_hit[l]) lo_lane = l;
        for (int l = 0; l < LANES; l++)
            if (lane_hit[l]) hi_lane = l;
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        hit_nxt   = hit_q;
        idx_nxt   = idx_q;
        case (state)
            IDLE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = SCAN;
                end
            end
            SCAN: begin
                if (|lane_hit) begin
                    hit_nxt = 1'b1;
                    idx_nxt = IDX_W'(int'(beat)*LANES + (mode_q ? hi_lane : lo_lane));
                end
                if ((!mode_q && |lane_hit) || beat == BEAT_W'(NUM_BEATS-1))
                    state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign size_nxt = LEN_W'((int'(idx_nxt) + 1) * SYM_W);

    always_ff @(posedge clk) begin
        if (rst) begin
            mess_q <= '0;
            term_q <= '0;
            mode_q <= 1'b0;
            beat   <= '0;
            hit_q  <= 1'b0;
            idx_q  <= '0;
            found  <= 1'b0;
            size   <= '0;
        end else begin
            if (accept) begin
                mess_q <= mess;
                term_q <= last_word;
                mode_q <= mode;
                beat   <= '0;
                hit_q  <= 1'b0;
                idx_q  <= '0;
            end else if (state == SCAN) begin
                mess_q <= mess_q >> (LANES*SYM_W);
                beat   <= beat + BEAT_W'(1);
                hit_q  <= hit_nxt;
                idx_q  <= idx_nxt;
            end
            // Result registers only move on DONE entry; a new start leaves
            // the previous result visible until the next scan completes.
            if (state == SCAN && state_nxt == DONE) begin
                found <= hit_nxt;
                size  <= hit_nxt ? size_nxt : '0;
            end
        end
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

endmodule

// File: tb/tb_msg_length_scanner.sv
module tb_msg_length_scanner;

    localparam int SYM_W   = 4;
    localparam int NUM_SYM = 128;
    localparam int LANES   = 8;
    localparam int LEN_W   = $clog2(NUM_SYM*SYM_W)+1;
    localparam int NB      = NUM_SYM / LANES;

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     start;
    logic [NUM_SYM*SYM_W-1:0] mess;
    logic [SYM_W-1:0]         last_word;
    logic                     mode;
    logic                     busy, done, found;
    logic [LEN_W-1:0]         size;

    logic [SYM_W-1:0] syms [NUM_SYM];
    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    msg_length_scanner #(.SYM_W(SYM_W), .NUM_SYM(NUM_SYM), .LANES(LANES)) dut (
        .clk(clk), .rst(rst), .start(start), .mess(mess), .last_word(last_word),
        .mode(mode), .busy(busy), .done(done), .found(found), .size(size)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [NUM_SYM*SYM_W-1:0] pack_syms();
        logic [NUM_SYM*SYM_W-1:0] m;
        for (int i = 0; i < NUM_SYM; i++) m[i*SYM_W +: SYM_W] = syms[i];
        return m;
    endfunction

    function automatic logic [NUM_SYM*SYM_W-1:0] rand_mess();
        logic [NUM_SYM*SYM_W-1:0] m;
        for (int i = 0; i < NUM_SYM; i++) m[i*SYM_W +: SYM_W] = SYM_W'($urandom);
        return m;
    endfunction

    task automatic fill(input logic [SYM_W-1:0] term);
        int v;
        for (int i = 0; i < NUM_SYM; i++) begin
            v = $urandom_range(0, (1 << SYM_W) - 2);
            if (v >= int'(term)) v++;
            syms[i] = SYM_W'(v);
        end
    endtask

    // Runs one scan on syms[]. Expected results come from a plain search
    // over the symbol array; plan_size/plan_lat (>=0) add fixed targets.
    task automatic run(input string tag, input logic [SYM_W-1:0] term, input logic m,
                       input bit poke, input int plan_size, input int plan_lat);
        int idx, exp_size, exp_lat, cyc;
        bit exp_found;
        idx = -1;
        for (int i = 0; i < NUM_SYM; i++)
            if (syms[i] == term && (m || idx < 0)) idx = i;
        exp_found = (idx >= 0);
        exp_size  = exp_found ? (idx + 1) * SYM_W : 0;
        exp_lat   = (!m && exp_found) ? idx / LANES + 2 : NB + 1;

        @(posedge clk); #1;
        mess = pack_syms(); last_word = term; mode = m; start = 1'b1;
        @(posedge clk); #1;
        // Scramble inputs right after acceptance; the scan must use latches.
        start = 1'b0; mess = rand_mess(); last_word = ~term; mode = ~m;
        cyc = 1;
        check({tag, " busy_c1"}, 32'(busy), 32'd1);
        while (done !== 1'b1 && cyc < NB + 5) begin
            start = (poke && cyc == 3);
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0;
        check({tag, " latency"}, 32'(cyc), 32'(exp_lat));
        check({tag, " found"}, 32'(found), 32'(exp_found));
        check({tag, " size"}, 32'(size), 32'(exp_size));
        if (plan_size >= 0) check({tag, " plan_size"}, 32'(size), 32'(plan_size));
        if (plan_lat >= 0)  check({tag, " plan_lat"}, 32'(cyc), 32'(plan_lat));
        @(posedge clk); #1;
        check({tag, " done_pulse"}, 32'(done), 32'd0);
        check({tag, " busy_after"}, 32'(busy), 32'd0);
        check({tag, " size_hold"}, 32'(size), 32'(exp_size));
        check({tag, " found_hold"}, 32'(found), 32'(exp_found));
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; start = 1'b0; mess = '0; last_word = '0; mode = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset found", 32'(found), 32'd0);
        check("reset size", 32'(size), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < NUM_SYM; i++) syms[i] = '0;
        syms[5] = 4'hA;
        run("single5_m0", 4'hA, 1'b0, 1'b0, 24, 2);

        for (int i = 0; i < NUM_SYM; i++) syms[i] = '0;
        syms[3] = 4'hA; syms[100] = 4'hA;
        run("dual_m0", 4'hA, 1'b0, 1'b0, 16, 2);
        run("dual_m1", 4'hA, 1'b1, 1'b0, 404, NB + 1);
        run("dual_m1_poke", 4'hA, 1'b1, 1'b1, 404, NB + 1);

        for (int i = 0; i < NUM_SYM; i++) syms[i] = '0;
        run("none", 4'hA, 1'b0, 1'b0, 0, NB + 1);

        syms[127] = 4'hA;
        run("idx127_m0", 4'hA, 1'b0, 1'b0, 512, NB + 1);

        for (int i = 0; i < NUM_SYM; i++) syms[i] = '0;
        syms[7] = 4'hA; syms[8] = 4'hA;
        run("lane78_m0", 4'hA, 1'b0, 1'b0, 32, 2);
        run("lane78_m1", 4'hA, 1'b1, 1'b0, 36, NB + 1);

        // Reset during beat 5 (cycle 6) with a prior non-zero result held.
        for (int i = 0; i < NUM_SYM; i++) syms[i] = '0;
        syms[60] = 4'h3;
        @(posedge clk); #1;
        mess = pack_syms(); last_word = 4'h3; mode = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) begin @(posedge clk); #1; end
        check("pre_rst busy", 32'(busy), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("mid_rst busy", 32'(busy), 32'd0);
        check("mid_rst done", 32'(done), 32'd0);
        check("mid_rst found", 32'(found), 32'd0);
        check("mid_rst size", 32'(size), 32'd0);
        @(posedge clk); #1;
        check("post_rst idle", 32'(busy), 32'd0);
        run("after_rst", 4'h3, 1'b1, 1'b0, 244, NB + 1);

        for (int r = 0; r < 40; r++) begin
            logic [SYM_W-1:0] term;
            int k;
            term = SYM_W'($urandom);
            fill(term);
            k = $urandom_range(0, 3);
            for (int j = 0; j < k; j++) syms[$urandom_range(0, NUM_SYM - 1)] = term;
            run($sformatf("rand%0d", r), term, 1'($urandom), 1'($urandom_range(0, 3) == 0), -1, -1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/msg_length_scanner.md
# msg_length_scanner

Sequential, parametrised message-length finder for the SHA-256 front end. It latches a message vector and a terminator symbol, then scans LANES symbols per clock. It reports the bit length up to and including the first or last terminator occurrence, selected by mode. The result feeds the padding/length-append stage; the multi-cycle scan replaces a single wide combinational priority chain so the 128-symbol case closes timing.

## Interface

Parameters:
- SYM_W, 4: symbol width in bits.
- NUM_SYM, 128: symbols per message.
- LANES, 8: symbols compared per clock. Must divide NUM_SYM; illegal values are an elaboration error.
- LEN_W, $clog2(NUM_SYM*SYM_W)+1: width of size.

Ports:
- clk  in  1  clock. One clock domain; all logic is rising-edge.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  request a scan. Accepted only when busy=0.
- mess  in  NUM_SYM*SYM_W  message. Symbol i is mess[i*SYM_W +: SYM_W]. Sampled only on an accepted start.
- last_word  in  SYM_W  terminator symbol. Sampled only on an accepted start.
- mode  in  1  match mode: 0 = first (lowest-index) match, 1 = last (highest-index) match. Sampled only on an accepted start.
- busy  out  1  high in SCAN and DONE.
- done  out  1  one-cycle pulse; the result is valid.
- found  out  1  at least one match occurred in the last scan.
- size  out  LEN_W  bit length (idx+1)*SYM_W of the selected match; 0 if none.

## Operation

- States: IDLE, SCAN, DONE. Reset enters IDLE.
- Accepted start in IDLE:
  - Latch mess, last_word and mode into internal registers.
  - Set beat counter to 0, clear the internal match and index registers, go to SCAN.
  - Inputs may change freely after acceptance.
- SCAN, beat b: compare symbols b*LANES … b*LANES+LANES-1 against the latched terminator.
  - Mode 0: on any match in the beat, record the lowest matching index and go to DONE immediately (early exit).
  - Mode 1: on any match, record the highest matching index in the beat, overwriting earlier records. Always continue to the final beat.
  - After beat NUM_SYM/LANES-1, go to DONE.
- DONE, one cycle:
  - done=1. found and size are loaded at the edge entering DONE.
  - found=1 and size=(idx+1)*SYM_W if a match was recorded; otherwise found=0, size=0.
  - DONE always returns to IDLE.
- found and size hold until the next DONE entry or reset. Entering SCAN on a new start does not clear them.
- start while busy=1 (SCAN or DONE) is ignored. No queuing.
- Size arithmetic is unsigned and computed at LEN_W width. The maximum (NUM_SYM*SYM_W) must not truncate.

## Timing

- Reset values: busy=0, done=0, found=0, size=0. Internal counter and latches are cleared.
- rst has priority over everything, including mid-SCAN and the DONE cycle. The result is discarded, and the next cycle is IDLE with all outputs at their reset values.
- Start sampled at edge E0: SCAN beat k occupies cycle k+1 after E0.
  - done is high in the cycle after the terminating beat.
  - Mode 0 with first match in beat k: done in cycle k+2.
  - Mode 1, or no match: done in cycle NUM_SYM/LANES+1 (cycle 17 with defaults).
- busy rises in the cycle after E0 and falls in the cycle after done.
- Minimum start-to-start spacing is latency+1 cycles. A start held high continuously re-triggers on the first IDLE cycle.
- No combinational path from any input to any output.

## Test plan

Defaults: SYM_W=4, NUM_SYM=128, LANES=8.

- Single match at index 5, last_word=0xA, mode 0 → done in cycle 2, found=1, size=24.
- Matches at indices 3 and 100, mode 0 → done in cycle 2, size=16.
- Same message, mode 1 → done in cycle 17, size=404.
- No match → done in cycle 17, found=0, size=0.
- Match only at index 127, mode 0 → done in cycle 17, size=512. Checks the LEN_W boundary.
- Match at index 7 (beat 0, top lane) and index 8 (beat 1, bottom lane), mode 0 → size=32. Same message, mode 1 → size=36. Checks lane boundaries.
- Scan in progress, then start pulsed with a different mess → ignored; the result matches the original message.
- mess changed the cycle after E0 → the result uses the latched value.
- rst asserted during beat 5 → next cycle busy=0, done=0, found=0, size=0, state IDLE.
- Fresh start after that reset → normal result.
